// File: rtl/mand_dispatch_if.sv
// Bus slave handshake bundle for the Mandelbrot job dispatcher.
// The master drives the cycle/strobe/address/data; the slave returns read data and ack.
interface mand_dispatch_if #(
  parameter int DW = 32
);
  logic          cyc_i;
  logic          stb_i;
  logic          we_i;
  logic [3:0]    adr_i;
  logic [DW-1:0] dat_i;
  logic [DW-1:0] dat_o;
  logic          ack_o;

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o
  );

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o
  );
endinterface

// File: rtl/mand_dispatch.sv
// Job dispatcher for a bank of Mandelbrot iteration cores: register file,
// lowest-free-core dispatch, lowest-index result collector and result FIFO.
//
// state  | meaning
// IDLE   | waiting for cyc_i & stb_i
// ACCESS | register read captured, write/dispatch/pop effects applied
// ACK    | ack_o high for one cycle, dat_o valid
module mand_dispatch #(
  parameter int NCORE = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  mand_dispatch_if.slave        bus,
  output logic                  irq_o,
  output logic [NCORE-1:0]      core_start_o,
  output logic [4*DW-1:0]       core_data_o,
  input  logic [NCORE-1:0]      core_done_i,
  input  logic [NCORE*5*DW-1:0] core_res_i,
  output logic [NCORE-1:0]      core_ack_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 5 * DW;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK} state_t;
  state_t state_q, state_d;

  logic          access;
  logic [DW-1:0] stage_q [4];
  logic [DW-1:0] res_q   [5];
  logic          irqen_q, rej_q, unf_q;
  logic [NCORE-1:0] busy_q;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          empty, full;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cyc_i && bus.stb_i) state_d = S_ACCESS;
      S_ACCESS: state_d = S_ACK;
      S_ACK:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    access    = (state_q == S_ACCESS);
    bus.ack_o = (state_q == S_ACK);
  end

  logic wr, dispatch, pop_req, pop, push, all_busy;
  logic [NCORE-1:0] free, disp_oh, cand, col_oh, col_ack;
  logic [EW-1:0] col_data;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign wr       = access && bus.we_i;
  assign dispatch = wr && (bus.adr_i == 4'd5);
  assign pop_req  = wr && (bus.adr_i == 4'd6);
  assign pop      = pop_req && !empty;
  assign free     = ~busy_q;
  assign all_busy = (free == '0);
  assign disp_oh  = free & (~free + NCORE'(1));
  // A core acked last cycle may still show done; skip it until it drops.
  assign cand     = core_done_i & ~core_ack_o;
  assign col_oh   = cand & (~cand + NCORE'(1));
  assign push     = (cand != '0) && (!full || pop);
  assign col_ack  = push ? col_oh : '0;

  always_comb begin
    col_data = '0;
    for (int i = 0; i < NCORE; i++)
      col_data = col_data | ({EW{col_oh[i]}} & core_res_i[i*EW +: EW]);
  end

  logic [DW-1:0] status, rd_data;
  always_comb begin
    status              = '0;
    status[NCORE-1:0]   = busy_q;
    status[16]          = empty;
    status[17]          = full;
    status[19]          = rej_q;
    status[20]          = unf_q;
    status[24 +: CW]    = cnt_q;
  end

  always_comb begin
    rd_data = '0;
    case (bus.adr_i)
      4'd0:  rd_data = stage_q[0];
      4'd1:  rd_data = stage_q[1];
      4'd2:  rd_data = stage_q[2];
      4'd3:  rd_data = stage_q[3];
      4'd4:  rd_data = status;
      4'd7:  rd_data = DW'(irqen_q);
      4'd8:  rd_data = res_q[0];
      4'd9:  rd_data = res_q[1];
      4'd10: rd_data = res_q[2];
      4'd11: rd_data = res_q[3];
      4'd12: rd_data = res_q[4];
      default: rd_data = '0;
    endcase
  end

  assign core_data_o = {stage_q[0], stage_q[1], stage_q[2], stage_q[3]};

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= col_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) stage_q[i] <= '0;
      for (int i = 0; i < 5; i++) res_q[i] <= '0;
      irqen_q      <= 1'b0;
      rej_q        <= 1'b0;
      unf_q        <= 1'b0;
      busy_q       <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      bus.dat_o    <= '0;
      core_start_o <= '0;
      core_ack_o   <= '0;
      irq_o        <= 1'b0;
    end else begin
      if (access) bus.dat_o <= rd_data;
      if (wr && bus.adr_i < 4'd4) stage_q[bus.adr_i[1:0]] <= bus.dat_i;
      if (wr && bus.adr_i == 4'd4) begin
        if (bus.dat_i[19]) rej_q <= 1'b0;
        if (bus.dat_i[20]) unf_q <= 1'b0;
      end
      if (wr && bus.adr_i == 4'd7) irqen_q <= bus.dat_i[0];
      if (dispatch && all_busy) rej_q <= 1'b1;
      core_start_o <= (dispatch && !all_busy) ? disp_oh : '0;
      busy_q <= (busy_q & ~col_ack) | ((dispatch && !all_busy) ? disp_oh : '0);
      core_ack_o <= col_ack;
      if (pop) begin
        res_q[0] <= mem_q[rptr_q][5*DW-1:4*DW];
        res_q[1] <= mem_q[rptr_q][4*DW-1:3*DW];
        res_q[2] <= mem_q[rptr_q][3*DW-1:2*DW];
        res_q[3] <= mem_q[rptr_q][2*DW-1:DW];
        res_q[4] <= mem_q[rptr_q][DW-1:0];
        rptr_q   <= rptr_q + AW'(1);
      end
      if (pop_req && empty) unf_q <= 1'b1;
      if (push) wptr_q <= wptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      irq_o <= irqen_q && !empty;
    end
  end
endmodule

// File: tb/tb_mand_dispatch.sv
// Directed bench for mand_dispatch: table of register accesses plus
// hand-written dispatch, collector, FIFO-full, interrupt and reset sequences.
module tb_mand_dispatch;
  localparam int NCORE = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic irq_o;
  logic [NCORE-1:0] core_start_o, core_done_i, core_ack_o;
  logic [4*DW-1:0] core_data_o;
  logic [NCORE*5*DW-1:0] core_res_i;
  logic [DW-1:0] res_iter [NCORE];

  int checks = 0;
  int errors = 0;

  mand_dispatch_if #(.DW(DW)) bus ();

  mand_dispatch #(.NCORE(NCORE), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .bus          (bus.slave),
    .irq_o        (irq_o),
    .core_start_o (core_start_o),
    .core_data_o  (core_data_o),
    .core_done_i  (core_done_i),
    .core_res_i   (core_res_i),
    .core_ack_o   (core_ack_o)
  );

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < NCORE; g++) begin : g_res
    assign core_res_i[g*5*DW +: 5*DW] =
      {32'h1000 + g, 32'h2000 + g, 32'h3000 + g, 32'h4000 + g, res_iter[g]};
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cores hold done until they see their ack pulse at a clock edge.
  task automatic tick();
    logic [NCORE-1:0] a;
    a = core_ack_o;
    @(posedge clk_i);
    #1;
    core_done_i = core_done_i & ~a;
  endtask

  task automatic bus_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [3:0] st, output logic [3:0] ca);
    int lat;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = we; bus.adr_i = adr; bus.dat_i = wd;
    lat = 0;
    while (bus.ack_o !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    rd = bus.dat_o; st = core_start_o; ca = core_ack_o;
    check("ack_latency", 128'(lat), 128'(2));
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    tick();
    check("ack_single", 128'(bus.ack_o), 128'(0));
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] d);
    logic [31:0] rd; logic [3:0] st, ca;
    bus_xfer(1'b1, adr, d, rd, st, ca);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] rd; logic [3:0] st, ca;
    bus_xfer(1'b0, adr, '0, rd, st, ca);
    check(name, 128'(rd), 128'(exp));
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[20];
    logic [3:0] exp_st [5];
    logic [31:0] rd;
    logic [3:0] st, ca, ack_seen;
    int guard;

    vecs[0]  = '{1'b1, 4'd0,  32'd1,        32'd0};
    vecs[1]  = '{1'b1, 4'd1,  32'd2,        32'd0};
    vecs[2]  = '{1'b1, 4'd2,  32'd3,        32'd0};
    vecs[3]  = '{1'b1, 4'd3,  32'd4,        32'd0};
    vecs[4]  = '{1'b0, 4'd0,  32'd0,        32'd1};
    vecs[5]  = '{1'b0, 4'd1,  32'd0,        32'd2};
    vecs[6]  = '{1'b0, 4'd2,  32'd0,        32'd3};
    vecs[7]  = '{1'b0, 4'd3,  32'd0,        32'd4};
    vecs[8]  = '{1'b1, 4'd0,  32'hA5A5,     32'd1};
    vecs[9]  = '{1'b0, 4'd0,  32'd0,        32'hA5A5};
    vecs[10] = '{1'b0, 4'd4,  32'd0,        32'h0001_0000};
    vecs[11] = '{1'b1, 4'd8,  32'hFFFF,     32'd0};
    vecs[12] = '{1'b0, 4'd8,  32'd0,        32'd0};
    vecs[13] = '{1'b0, 4'd12, 32'd0,        32'd0};
    vecs[14] = '{1'b1, 4'd13, 32'h1234,     32'd0};
    vecs[15] = '{1'b0, 4'd13, 32'd0,        32'd0};
    vecs[16] = '{1'b0, 4'd7,  32'd0,        32'd0};
    vecs[17] = '{1'b1, 4'd7,  32'hFFFF_FFFF, 32'd0};
    vecs[18] = '{1'b0, 4'd7,  32'd0,        32'd1};
    vecs[19] = '{1'b1, 4'd7,  32'd0,        32'd1};
    exp_st = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0; bus.adr_i = '0; bus.dat_i = '0;
    core_done_i = '0;
    for (int i = 0; i < NCORE; i++) res_iter[i] = '0;
    #1;
    check("reset_ack", 128'(bus.ack_o), 128'(0));
    check("reset_dat", 128'(bus.dat_o), 128'(0));
    tick(); tick();
    rst_i = 1'b0;
    tick();

    // Register file table
    for (int k = 0; k < 20; k++) begin
      bus_xfer(vecs[k].we, vecs[k].adr, vecs[k].wd, rd, st, ca);
      check($sformatf("vec%0d_adr%0d", k, vecs[k].adr), 128'(rd), 128'(vecs[k].exp));
    end
    check("core_data", 128'(core_data_o), {32'hA5A5, 32'd2, 32'd3, 32'd4});

    // Dispatch to lowest free core; fifth is rejected
    for (int k = 0; k < 5; k++) begin
      bus_xfer(1'b1, 4'd5, '0, rd, st, ca);
      check($sformatf("dispatch%0d", k), 128'(st), 128'(exp_st[k]));
      if (k == 0) check("start_pulse_width", 128'(core_start_o), 128'(0));
    end
    rd_chk("status_all_busy", 4'd4, 32'h0009_000F);
    wr(4'd4, 32'h0008_0000);
    rd_chk("status_rej_clr", 4'd4, 32'h0001_000F);

    // Two simultaneous dones collected lowest-first
    res_iter[1] = 32'h111;
    res_iter[2] = 32'h222;
    core_done_i = 4'b0110;
    tick();
    check("col_ack_first", 128'(core_ack_o), 128'(4'b0010));
    tick();
    check("col_ack_second", 128'(core_ack_o), 128'(4'b0100));
    tick();
    check("col_ack_idle", 128'(core_ack_o), 128'(4'b0000));
    rd_chk("status_two_results", 4'd4, 32'h0200_0009);
    check("irq_disabled", 128'(irq_o), 128'(0));
    wr(4'd6, '0);
    rd_chk("pop1_iter", 4'd12, 32'h111);
    rd_chk("pop1_x0", 4'd8, 32'h1001);
    rd_chk("pop1_yn1", 4'd11, 32'h4001);
    wr(4'd6, '0);
    rd_chk("pop2_iter", 4'd12, 32'h222);

    // Interrupt on one pending result, underflow on empty pop
    wr(4'd7, 32'd1);
    res_iter[3] = 32'h777;
    core_done_i = 4'b1000;
    tick(); tick(); tick();
    check("irq_set", 128'(irq_o), 128'(1));
    wr(4'd6, '0);
    check("irq_clr", 128'(irq_o), 128'(0));
    rd_chk("pop3_iter", 4'd12, 32'h777);
    wr(4'd6, '0);
    rd_chk("pop_underflow_keeps", 4'd12, 32'h777);
    rd_chk("status_underflow", 4'd4, 32'h0011_0001);
    wr(4'd4, 32'h0018_0000);

    // Fill FIFO from core 1, then backpressure core 0
    for (int k = 0; k < DEPTH; k++) begin
      res_iter[1] = 32'h500 + k;
      core_done_i[1] = 1'b1;
      guard = 0;
      while (core_done_i[1] && guard < 10) begin
        tick();
        guard++;
      end
      if (guard >= 10) check($sformatf("fill%0d_timeout", k), 128'(core_done_i[1]), 128'(0));
    end
    res_iter[0] = 32'h999;
    core_done_i[0] = 1'b1;
    ack_seen = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      ack_seen = ack_seen | core_ack_o;
    end
    check("full_no_ack", 128'(ack_seen), 128'(0));
    check("irq_full", 128'(irq_o), 128'(1));
    rd_chk("status_full", 4'd4, 32'h1002_0001);
    bus_xfer(1'b1, 4'd6, '0, rd, st, ca);
    check("full_pop_push_ack", 128'(ca), 128'(4'b0001));
    rd_chk("status_full_after_pop", 4'd4, 32'h1002_0000);
    rd_chk("full_pop_iter", 4'd12, 32'h500);

    // Reset in the middle of an access
    core_done_i = '0;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1; bus.adr_i = 4'd0; bus.dat_i = 32'h77;
    tick();
    #2 rst_i = 1'b1;
    #1;
    check("rst_ack", 128'(bus.ack_o), 128'(0));
    check("rst_irq", 128'(irq_o), 128'(0));
    check("rst_start", 128'(core_start_o), 128'(0));
    check("rst_core_ack", 128'(core_ack_o), 128'(0));
    check("rst_dat", 128'(bus.dat_o), 128'(0));
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    tick();
    check("rst_ack_held", 128'(bus.ack_o), 128'(0));
    tick();
    rst_i = 1'b0;
    tick();
    rd_chk("status_after_rst", 4'd4, 32'h0001_0000);
    rd_chk("stage0_after_rst", 4'd0, 32'd0);
    rd_chk("irqen_after_rst", 4'd7, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mand_dispatch.md
MAND_DISPATCH -- requirements
Module: mand_dispatch

Interface
REQ-001 SHALL have parameter NCORE, default 4, number of attached Mandelbrot iteration cores (1..8).
REQ-002 SHALL have parameter DW, default 32, data/coordinate word width.
REQ-003 SHALL have parameter DEPTH, default 16, result FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk_i  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have bus slave ports cyc_i, stb_i, we_i (in, 1 each), adr_i (in, 4), dat_i (in, DW), dat_o (out, DW), ack_o (out, 1).
REQ-007 SHALL have port irq_o  out  1  result-available interrupt.
REQ-008 SHALL have port core_start_o  out  NCORE  one-cycle job-start pulse per core.
REQ-009 SHALL have port core_data_o  out  4*DW  {x0,y0,xn,yn} from staging registers, shared by all cores.
REQ-010 SHALL have port core_done_i  in  NCORE  per-core result-valid, held until acknowledged.
REQ-011 SHALL have port core_res_i  in  NCORE*5*DW  per-core {x0,y0,xn1,yn1,iter}, core i at bits [(i+1)*5*DW-1 : i*5*DW].
REQ-012 SHALL have port core_ack_o  out  NCORE  one-cycle result-accept pulse per core.

Function
REQ-013 Bus FSM SHALL have states IDLE, ACCESS, ACK; IDLE->ACCESS when cyc_i&stb_i, ACCESS->ACK always, ACK->IDLE always.
REQ-014 ack_o SHALL be high only in ACK (exactly one cycle per access); dat_o SHALL be registered and valid while ack_o is high.
REQ-015 Register effects SHALL occur on the ACCESS cycle using adr_i/we_i/dat_i sampled then.
REQ-016 adr 0-3 SHALL be staging x0,y0,xn,yn, read/write.
REQ-017 adr 4 SHALL be STATUS (read): [NCORE-1:0] busy mask, [16] FIFO empty, [17] FIFO full, [19] reject sticky, [20] underflow sticky, [31:24] FIFO used count; write of 1 to bit 19/20 clears it.
REQ-018 Write to adr 5 (DISPATCH) SHALL pulse core_start_o of lowest-index non-busy core and set its busy bit; if all busy, SHALL set reject sticky and pulse nothing.
REQ-019 Write to adr 6 (POP) SHALL load FIFO head into result registers adr 8-12 and remove it; if empty, results unchanged and underflow sticky set.
REQ-020 adr 7 SHALL be IRQEN, bit 0 read/write; irq_o SHALL equal IRQEN[0] & !empty, registered.
REQ-021 adr 8-12 SHALL be read-only result x0,y0,xn1,yn1,iter; writes ignored. Other addresses SHALL read 0, writes ignored, ack still given.
REQ-022 Reads of adr 0-12 SHALL return register value before any same-access update.
REQ-023 Collector SHALL each cycle select lowest-index i with core_done_i[i] & !core_ack_o[i]; if FIFO not full, pulse core_ack_o[i], push core i result, clear busy[i].
REQ-024 FIFO full SHALL backpressure (no ack, no loss); cores hold core_done_i.
REQ-025 Push and pop in the same cycle SHALL be legal in any occupancy, including full; count unchanged.
REQ-026 Dispatch and collector ack on the same core in the same cycle SHALL not occur: busy cleared on ack, dispatch sees pre-cycle busy.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; used count width log2(DEPTH)+1.

Reset
REQ-028 On rst_i: FSM IDLE; ack_o, irq_o, core_start_o, core_ack_o = 0; all registers, busy, stickies = 0; FIFO empty; dat_o = 0.
REQ-029 Reset mid-access SHALL abort it with no ack; reset SHALL not require clock.

Verification
REQ-030 Write adr0..3 = 1,2,3,4, read back -> each ack one cycle, two cycles after stb, dat_o 1,2,3,4.
REQ-031 Five DISPATCH writes, NCORE=4, no dones -> core_start_o 0001,0010,0100,1000, then none; STATUS busy=0xF, bit19=1.
REQ-032 core_done_i=0b0110 same cycle -> core_ack_o 0010 then 0100 on successive cycles; used count 1 then 2.
REQ-033 Fill FIFO to DEPTH, hold core0 done -> no core_ack_o, STATUS[17]=1; POP -> core0 acked next cycle, count stays DEPTH.
REQ-034 IRQEN=1, one result -> irq_o=1; POP -> adr12 reads pushed iter, irq_o=0; POP again -> STATUS[20]=1.
REQ-035 Assert rst_i during ACCESS -> no ack_o, all outputs 0, STATUS reads 0x00010000 after release.
